// File: rtl/bk_multiprecision_adder.sv
`default_nettype none
// ============================================================================
// Module   : bk_multiprecision_adder (with brent_kung_generic)
// Brief    : Streaming limb-serial multi-precision adder around a Brent-Kung
//            prefix adder, with a post-increment stage for the inter-limb carry.
// Revision : 1.0
// ============================================================================

module brent_kung_generic #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int LOG = $clog2(N);

    logic [N-1:0] w_prop;
    logic [N-1:0] w_carry;

    assign w_prop = a ^ b;

    // Up-sweep builds group (G,P) at power-of-two boundaries; down-sweep fills the gaps.
    always_comb begin : bk_prefix
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] gp;
        logic [N-1:0] pp;
        int           j;
        g = a & b;
        p = w_prop;
        for (int l = 0; l < LOG; l++) begin
            gp = g;
            pp = p;
            for (int i = 0; i < N; i++) begin
                j = (i >= (1 << l)) ? i - (1 << l) : i;
                if (((i + 1) % (1 << (l + 1))) == 0) begin
                    g[i] = gp[i] | (pp[i] & gp[j]);
                    p[i] = pp[i] & pp[j];
                end
            end
        end
        for (int l = LOG - 2; l >= 0; l--) begin
            gp = g;
            pp = p;
            for (int i = 0; i < N; i++) begin
                j = (i >= (1 << l)) ? i - (1 << l) : i;
                if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && ((i + 1) > (1 << (l + 1)))) begin
                    g[i] = gp[i] | (pp[i] & gp[j]);
                    p[i] = pp[i] & pp[j];
                end
            end
        end
        w_carry = g;
    end

    assign sum  = w_prop ^ {w_carry[N-2:0], 1'b0};
    assign cout = w_carry[N-1];
endmodule

module bk_multiprecision_adder #(
    parameter int N     = 64,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_carry,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx
);
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_MID  = 1'b1;

    logic             state_q, state_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             w_accept;
    logic [N-1:0]     w_s;
    logic [N-1:0]     w_r;
    logic             w_c0;
    logic             w_c;

    brent_kung_generic #(.N(N)) u_bk (
        .a    (in_a),
        .b    (in_b),
        .sum  (w_s),
        .cout (w_c0)
    );

    // c0 and increment overflow cannot both be set, so OR is exact.
    assign w_r = w_s + {{(N-1){1'b0}}, carry_q};
    assign w_c = w_c0 | (carry_q & (&w_s));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept && !in_last) begin
                    state_d = ST_MID;
                    carry_d = w_c;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_MID: begin
                if (w_accept) begin
                    if (in_last) begin
                        state_d = ST_IDLE;
                        carry_d = 1'b0;
                        idx_d   = '0;
                    end else begin
                        carry_d = w_c;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                carry_d = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready = !out_valid || out_ready;
        w_accept = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            out_sum   <= w_r;
            out_carry <= w_c;
            out_last  <= in_last;
            out_idx   <= idx_q;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_bk_multiprecision_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bk_multiprecision_adder
// Brief    : Scoreboard bench for bk_multiprecision_adder with N=8, IDX_W=4.
// Revision : 1.0
// ============================================================================
module tb_bk_multiprecision_adder;
    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic       last;
        logic [3:0] idx;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_carry;
    logic       out_last;
    logic [3:0] out_idx;

    beat_t exp_q[$];
    beat_t mon_act;
    int    checks   = 0;
    int    failures = 0;

    bk_multiprecision_adder #(.N(8), .IDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_last  (out_last),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Peek at the head while stalled (catches output drift), pop on consume.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            mon_act.sum   = out_sum;
            mon_act.carry = out_carry;
            mon_act.last  = out_last;
            mon_act.idx   = out_idx;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat actual sum=%02h carry=%0b last=%0b idx=%0d required none",
                         out_sum, out_carry, out_last, out_idx);
            end else begin
                if (mon_act !== exp_q[0]) begin
                    failures++;
                    $display("FAIL beat actual sum=%02h carry=%0b last=%0b idx=%0d required sum=%02h carry=%0b last=%0b idx=%0d",
                             mon_act.sum, mon_act.carry, mon_act.last, mon_act.idx,
                             exp_q[0].sum, exp_q[0].carry, exp_q[0].last, exp_q[0].idx);
                end
                if (!out_ready) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL in_ready_stall actual=%0b required=0", in_ready);
                    end
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last,
                        input logic [7:0] es, input logic ec, input logic [3:0] ei);
        bit    acc;
        int    waited;
        beat_t e;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        acc      = 1'b0;
        waited   = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                e.sum   = es;
                e.carry = ec;
                e.last  = last;
                e.idx   = ei;
                exp_q.push_back(e);
            end
            #1;
            waited++;
            if (!acc && waited > 50) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=not_accepted required=accepted");
                break;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_out_sum"},   32'(out_sum),   32'h0);
        chk({tag, "_out_carry"}, 32'(out_carry), 32'h0);
        chk({tag, "_out_last"},  32'(out_last),  32'h0);
        chk({tag, "_out_idx"},   32'(out_idx),   32'h0);
    endtask

    initial begin
        int w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single limb
        send(8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 4'd0);
        idle();
        @(posedge clk);
        #1;

        // Three-limb chain
        send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'd0);
        send(8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 4'd1);
        send(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 4'd2);
        idle();

        // Final carry through increment overflow, then operand boundary
        send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'd0);
        send(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 4'd1);
        send(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 4'd0);
        idle();
        @(posedge clk);
        #1;

        // Backpressure: three stalled cycles mid-stream
        fork
            begin
                send(8'h12, 8'hF0, 1'b0, 8'h02, 1'b1, 4'd0);
                send(8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 4'd1);
                send(8'hFF, 8'h01, 1'b0, 8'h01, 1'b1, 4'd2);
                send(8'h34, 8'h00, 1'b1, 8'h35, 1'b0, 4'd3);
                idle();
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        @(posedge clk);
        #1;

        // Index wrap with the carry chaining across it
        for (int i = 0; i < 18; i++) begin
            send(8'hFF, (i == 0) ? 8'h01 : 8'h00, (i == 17), 8'h00, 1'b1, 4'(i));
        end
        idle();
        @(posedge clk);
        #1;

        // Reset mid-operand
        send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'd0);
        idle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'h05, 8'h03, 1'b1, 8'h08, 1'b0, 4'd0);
        idle();

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        chk("drain_remaining", 32'(exp_q.size()), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_out_valid", 32'(out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
